// File: rtl/jk_cnt_pkg.sv
// Shared types and helpers for the JK-cell modulo counter: the excitation
// encoding {J,K} and the wrap-aware next-count arithmetic.
package jk_cnt_pkg;

    // Wide enough for WIDTH=16 plus one guard bit, so MODULUS=2**WIDTH never aliases.
    localparam int unsigned CNT_EXT_W = 17;

    typedef logic [CNT_EXT_W-1:0] cnt_ext_t;

    localparam cnt_ext_t CNT_ONE = cnt_ext_t'(1);

    // {J,K} pairs as presented to a JK cell.
    typedef enum logic [1:0] {
        JK_HOLD = 2'b00,
        JK_CLR  = 2'b01,
        JK_SET  = 2'b10,
        JK_TOG  = 2'b11
    } jk_exc_e;

    function automatic jk_exc_e jk_excite(input logic cur, input logic nxt);
        return jk_exc_e'({nxt & ~cur, ~nxt & cur});
    endfunction

    function automatic cnt_ext_t mod_next(input cnt_ext_t q, input logic up, input cnt_ext_t modulus);
        cnt_ext_t r;
        if (q >= modulus) begin
            r = '0;
        end else if (up) begin
            r = (q == modulus - CNT_ONE) ? '0 : q + CNT_ONE;
        end else begin
            r = (q == '0) ? modulus - CNT_ONE : q - CNT_ONE;
        end
        return r;
    endfunction

    function automatic cnt_ext_t sat_load(input cnt_ext_t data, input cnt_ext_t modulus);
        return (data < modulus) ? data : modulus - CNT_ONE;
    endfunction

endpackage

// File: rtl/jk_mod_counter_cell.sv
// Single JK storage cell (module jk_cell): hold / set / clear / toggle with a
// synchronous active-high reset. Q and Qn are both exposed.
module jk_cell (
    input  logic iClk,
    input  logic iRst,
    input  logic iJ,
    input  logic iK,
    output logic oQ,
    output logic oQn
);
    import jk_cnt_pkg::*;

    logic r_q = 1'b0;

    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_q <= 1'b0;
        end else begin
            case ({iJ, iK})
                JK_HOLD: r_q <= r_q;
                JK_SET:  r_q <= 1'b1;
                JK_CLR:  r_q <= 1'b0;
                default: r_q <= ~r_q;
            endcase
        end
    end

    assign oQ  = r_q;
    assign oQn = ~r_q;

endmodule

// File: rtl/jk_mod_counter.sv
// Up/down modulo counter built from WIDTH JK cells, with terminal count and a
// registered wrap pulse. Define JK_CNT_LOAD_EN to add the iLoad/iData port pair.
module jk_mod_counter #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             iEn,
    input  logic             iUp,
`ifdef JK_CNT_LOAD_EN
    input  logic             iLoad,
    input  logic [WIDTH-1:0] iData,
`endif
    output logic [WIDTH-1:0] oQ,
    output logic [WIDTH-1:0] oQn,
    output logic             oTc,
    output logic             oWrap
);
    import jk_cnt_pkg::*;

    generate
        if (WIDTH < 1 || WIDTH > 16) begin : g_bad_width
            $error("jk_mod_counter: WIDTH must be in 1..16");
        end
        if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
            $error("jk_mod_counter: MODULUS must be in 2..2**WIDTH");
        end
    endgenerate

    localparam cnt_ext_t MOD_L = cnt_ext_t'(MODULUS);

    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_qn;
    logic [WIDTH-1:0] w_nxt;
    logic [WIDTH-1:0] w_j;
    logic [WIDTH-1:0] w_k;
    cnt_ext_t         w_q_ext;
    cnt_ext_t         w_load_val;
    logic             w_load;
    logic             w_tc;
    logic             r_wrap = 1'b0;

    assign w_q_ext = cnt_ext_t'(w_q);

`ifdef JK_CNT_LOAD_EN
    assign w_load     = iLoad;
    assign w_load_val = sat_load(cnt_ext_t'(iData), MOD_L);
`else
    assign w_load     = 1'b0;
    assign w_load_val = '0;
`endif

    // Reset is applied inside each cell, so only load/enable shape the next count here.
    always_comb begin
        w_nxt = w_q;
        if (w_load) begin
            w_nxt = WIDTH'(w_load_val);
        end else if (iEn) begin
            w_nxt = WIDTH'(mod_next(w_q_ext, iUp, MOD_L));
        end
    end

    always_comb begin
        w_tc = 1'b0;
        if (iEn && !w_load) begin
            if (iUp) begin
                w_tc = (w_q_ext == MOD_L - CNT_ONE);
            end else begin
                w_tc = (w_q_ext == '0);
            end
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign {w_j[i], w_k[i]} = jk_excite(w_q[i], w_nxt[i]);

        jk_cell u_cell (
            .iClk (iClk),
            .iRst (iRst),
            .iJ   (w_j[i]),
            .iK   (w_k[i]),
            .oQ   (w_q[i]),
            .oQn  (w_qn[i])
        );
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_wrap <= 1'b0;
        end else begin
            r_wrap <= w_tc;
        end
    end

    assign oQ    = w_q;
    assign oQn   = w_qn;
    assign oTc   = w_tc;
    assign oWrap = r_wrap;

endmodule

// File: tb/tb_jk_mod_counter.sv
// Scoreboard bench for jk_mod_counter: a mod-10 and a mod-16 instance share
// stimulus; a modular-arithmetic reference model predicts every cycle.
module tb_jk_mod_counter;

    localparam int W  = 4;
    localparam int MA = 10;
    localparam int MB = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst  = 1'b1;
    logic         en   = 1'b0;
    logic         up   = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] data = '0;

    logic [W-1:0] qa, qna, qb, qnb;
    logic         tca, wa, tcb, wb;

    jk_mod_counter #(.WIDTH(W), .MODULUS(MA)) u_dut_a (
        .iClk  (clk),
        .iRst  (rst),
        .iEn   (en),
        .iUp   (up),
`ifdef JK_CNT_LOAD_EN
        .iLoad (load),
        .iData (data),
`endif
        .oQ    (qa),
        .oQn   (qna),
        .oTc   (tca),
        .oWrap (wa)
    );

    jk_mod_counter #(.WIDTH(W), .MODULUS(MB)) u_dut_b (
        .iClk  (clk),
        .iRst  (rst),
        .iEn   (en),
        .iUp   (up),
`ifdef JK_CNT_LOAD_EN
        .iLoad (load),
        .iData (data),
`endif
        .oQ    (qb),
        .oQn   (qnb),
        .oTc   (tcb),
        .oWrap (wb)
    );

    typedef struct {
        int tc_a;
        int tc_b;
        int q_a;
        int q_b;
        int wrap_a;
        int wrap_b;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   m_qa     = 0;
    int   m_qb     = 0;

    function automatic int model_next(int q, int m, bit r, bit e, bit u, bit l, int d);
        if (r) return 0;
        if (l) return (d < m) ? d : m - 1;
        if (!e) return q;
        if (q >= m) return 0;
        return u ? (q + 1) % m : (q + m - 1) % m;
    endfunction

    function automatic int model_tc(int q, int m, bit e, bit u, bit l);
        if (!e || l) return 0;
        return u ? int'(q == m - 1) : int'(q == 0);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus: inputs settle shortly after the edge, the model
    // predicts oTc for this cycle and the state after the next edge.
    task automatic drive(input bit r, input bit e, input bit u, input bit l, input int d);
        exp_t x;
        logic [31:0] dv;
        @(posedge clk);
        #2;
        dv   = d;
        rst  = r;
        en   = e;
        up   = u;
        load = l;
        data = dv[W-1:0];
        x.tc_a   = model_tc(m_qa, MA, e, u, l);
        x.tc_b   = model_tc(m_qb, MB, e, u, l);
        m_qa     = model_next(m_qa, MA, r, e, u, l, int'(dv[W-1:0]));
        m_qb     = model_next(m_qb, MB, r, e, u, l, int'(dv[W-1:0]));
        x.q_a    = m_qa;
        x.q_b    = m_qb;
        x.wrap_a = r ? 0 : x.tc_a;
        x.wrap_b = r ? 0 : x.tc_b;
        sb.push_back(x);
    endtask

    initial begin : monitor
        exp_t y;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                y = sb.pop_front();
                check("tc_a", 32'(tca), y.tc_a);
                check("tc_b", 32'(tcb), y.tc_b);
                @(posedge clk);
                #1;
                check("q_a",    32'(qa),  y.q_a);
                check("qn_a",   32'(qna), ((1 << W) - 1) ^ y.q_a);
                check("wrap_a", 32'(wa),  y.wrap_a);
                check("q_b",    32'(qb),  y.q_b);
                check("qn_b",   32'(qnb), ((1 << W) - 1) ^ y.q_b);
                check("wrap_b", 32'(wb),  y.wrap_b);
            end
        end
    end

    initial begin : stimulus
        bit r, e, u, l;
        drive(1, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        repeat (12) drive(0, 1, 1, 0, 0);

        drive(1, 0, 1, 0, 0);
        repeat (3) drive(0, 1, 0, 0, 0);

        drive(1, 0, 0, 0, 0);
        repeat (5) drive(0, 1, 1, 0, 0);
        repeat (3) drive(0, 0, 1, 0, 0);
        for (int i = 0; i < 4; i++) drive(0, 1, (i % 2) == 0, 0, 0);
        repeat (2) drive(0, 1, 1, 0, 0);
        drive(1, 1, 1, 0, 0);
        drive(0, 1, 1, 0, 0);

        drive(1, 0, 0, 0, 0);
        repeat (17) drive(0, 1, 1, 0, 0);

`ifdef JK_CNT_LOAD_EN
        drive(0, 0, 0, 1, 12);
        drive(0, 1, 1, 1, 9);
        drive(1, 0, 0, 1, 3);
        drive(0, 1, 1, 1, 4);
        drive(0, 1, 0, 1, 15);
`endif

        for (int i = 0; i < 300; i++) begin
            r = ($urandom_range(0, 29) == 0);
            e = ($urandom_range(0, 4) != 0);
            u = $urandom_range(0, 1) != 0;
`ifdef JK_CNT_LOAD_EN
            l = ($urandom_range(0, 9) == 0);
`else
            l = 1'b0;
`endif
            drive(r, e, u, l, int'($urandom_range(0, (1 << W) - 1)));
        end

        for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
        repeat (3) @(posedge clk);
        check("scoreboard_drain", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/jk_mod_counter.md
Name: jk_mod_counter

Overview:
- Parametrised synchronous up/down modulo counter built from a bank of WIDTH JK storage cells, one per bit. It is the successor of the single-bit JK flip-flop.
- Each bit is driven by J/K excitation derived from the desired next count. Q and Qn are exposed per bit.
- Adds synchronous reset, count enable, direction, modulus wrap, terminal-count flag and a registered wrap pulse.
- Serves as a generic event/timebase counter in the digital-logic lab designs.

Parameters:
- WIDTH, 4, number of counter bits / JK cells (1..16).
- MODULUS, 10, count range 0..MODULUS-1; legal range 2..2**WIDTH. An illegal value must fail elaboration (generate-time check).

Ports:
- iClk  input  1  single clock; all state updates on its rising edge.
- iRst  input  1  synchronous, active-high reset.
- iEn  input  1  count enable.
- iUp  input  1  direction: 1 = up, 0 = down; sampled only when counting.
- oQ  output  WIDTH  current count (JK cell Q outputs).
- oQn  output  WIDTH  bitwise complement of oQ (JK cell Qn outputs).
- oTc  output  1  combinational terminal count.
- oWrap  output  1  registered one-cycle pulse following a wrap.
- iLoad, iData  present only with JK_CNT_LOAD_EN; see Optional Feature.

Behaviour:
- Reset: iClk rising edge with iRst=1 gives oQ=0, oQn=all ones, oWrap=0. iRst overrides every other input. Reset asserted mid-count takes effect on that same edge.
- Power-up: register initial value is 0, matching the existing flip-flop style.
- Next-value computation (iRst=0, iEn=1):
  - Up: nxt = (Q==MODULUS-1) ? 0 : Q+1.
  - Down: nxt = (Q==0) ? MODULUS-1 : Q-1.
  - iEn=0: nxt = Q (hold).
- Arithmetic: done in WIDTH+1 bits, no overflow aliasing. MODULUS=2**WIDTH must wrap cleanly (e.g. WIDTH=4: 15 -> 0).
- Excitation per bit i: J_i = nxt_i & ~Q_i, K_i = ~nxt_i & Q_i.
  - Resulting cell actions: J=K=0 hold; J=1 set; K=1 clear.
  - J=K=1 toggle is never produced by the counter, but the cell must still implement it.
- Latency: oQ reflects a count step one cycle after the enabling edge.
- oTc = iEn & ((iUp & Q==MODULUS-1) | (~iUp & Q==0)). Purely combinational, asserted in the cycle before the wrap edge.
- oWrap: registered copy of oTc, so it is high for exactly one cycle after each wrap. Cleared by reset.
- Direction change: takes effect on the next enabled edge; no extra latency or glitch count.
- Out-of-range state (Q >= MODULUS, reachable only via X/upset): next enabled edge loads 0 in either direction. oTc=0 while out of range.

Optional Feature:
- Macro: JK_CNT_LOAD_EN.
- Defined:
  - Adds ports iLoad (input, 1) and iData (input, WIDTH).
  - Priority on each edge: iRst > iLoad > iEn.
  - iLoad=1 sets nxt = iData if iData < MODULUS, else MODULUS-1 (saturate). The load ignores iEn and iUp.
  - oWrap is 0 on a load cycle; oTc is forced 0 while iLoad=1.
- Undefined: the ports are absent and the counter is exactly as above.

Decomposition:
- Package jk_cnt_pkg holds:
  - Excitation encoding constants: JK_HOLD, JK_SET, JK_CLR, JK_TOG.
  - Function jk_excite(cur, nxt) returning {J,K}.
  - Function mod_next(q, up, modulus).
- Sub-module jk_cell: 1-bit JK flop with sync active-high reset. Ports iClk, iRst, iJ, iK, oQ, oQn. Instantiated WIDTH times in a generate loop.

Test Plan (WIDTH=4, MODULUS=10 unless noted):
- Reset then iEn=1, iUp=1 for 12 cycles -> oQ 1,2,...,9,0,1,2. oTc high while Q=9. oWrap high exactly one cycle, with Q=0.
- Down count from reset, iEn=1, iUp=0 -> first edge gives Q=9, then 8. oTc high at Q=0 before that edge. oQn == ~oQ every cycle.
- Hold/direction: iEn=0 at Q=5 for 3 cycles -> Q stays 5, oTc=0. Then iUp toggled per cycle with iEn=1 -> 6,5,6,5.
- Mid-count reset: iRst=1 at Q=7 with iEn=1 -> next edge Q=0, oWrap=0. Counting resumes 1 on the following edge.
- WIDTH=4, MODULUS=16, up from 14 -> 15, 0, 1. oWrap pulses after 15->0.
- JK_CNT_LOAD_EN: iLoad=1, iData=12 -> Q=9 (saturated). iLoad=1, iData=3 together with iRst=1 -> Q=0. iLoad=1, iData=4 with iEn=1 -> Q=4, oWrap=0.
